// File: rtl/sum_pkg.sv
// Shared types and constants for the sum sequencer: FSM states, key codes, datapath widths.
package sum_pkg;

    localparam int OPERAND_W = 12;
    localparam int RESULT_W  = 16;
    localparam int KEY_W     = 4;

    localparam int unsigned OPERAND_MAX = 999;

    localparam logic [KEY_W-1:0] KEY_NEXT = 4'hA;
    localparam logic [KEY_W-1:0] KEY_CLR  = 4'hB;

    typedef enum logic [2:0] {
        ST_ENTER_A,
        ST_ENTER_B,
        ST_ADD,
        ST_LATCH,
        ST_CONV,
        ST_WAIT,
        ST_SHOW
    } state_e;

    function automatic logic is_digit(input logic [KEY_W-1:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/sum_digit_acc.sv
// One decimal operand accumulator: shifts in digits as value*10+d, bounded by a digit count and by 999.
module sum_digit_acc
    import sum_pkg::*;
#(
    parameter int MAX_DIGITS = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 set_i,
    input  logic                 push_i,
    input  logic [KEY_W-1:0]     digit_i,
    output logic [OPERAND_W-1:0] value_o
);

    localparam int CNT_W  = (MAX_DIGITS < 1) ? 1 : $clog2(MAX_DIGITS + 1);
    localparam int WIDE_W = OPERAND_W + 4;

    logic [OPERAND_W-1:0] value_q, value_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [WIDE_W-1:0]    shifted;
    logic                 has_room;
    logic                 fits;

    // value*10 as (value<<3)+(value<<1), evaluated wide so the 999 bound can be checked
    assign shifted  = ({4'd0, value_q} << 3) + ({4'd0, value_q} << 1) + WIDE_W'(digit_i);
    assign has_room = count_q < CNT_W'(MAX_DIGITS);
    assign fits     = shifted <= WIDE_W'(OPERAND_MAX);

    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (set_i) begin
            value_d = OPERAND_W'(digit_i);
            count_d = CNT_W'(1);
        end else if (clr_i) begin
            value_d = '0;
            count_d = '0;
        end else if (push_i && has_room && fits) begin
            value_d = shifted[OPERAND_W-1:0];
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= '0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/sum_sequencer.sv
// Keypad-driven two-operand sum sequencer: enter operands, add, latch, convert, display.
// Optional conversion watchdog enabled by defining SEQ_TIMEOUT_EN.
module sum_sequencer
    import sum_pkg::*;
#(
    parameter int MAX_DIGITS   = 3,
    parameter int CONV_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_valid,
    input  logic [KEY_W-1:0]     key_code,
    input  logic                 suma_btn,
    input  logic [RESULT_W-1:0]  resultado,
    input  logic                 conv_listo,
    output logic [OPERAND_W-1:0] num1,
    output logic [OPERAND_W-1:0] num2,
    output logic                 add_en,
    output logic [RESULT_W-1:0]  conv_value,
    output logic                 conv_start,
    output logic                 disp_load,
    output logic                 busy,
    output logic                 err
);

    state_e                state_q, state_d;
    logic                  btn_prev_q;
    logic [RESULT_W-1:0]   conv_value_q;
    logic                  disp_load_q, disp_load_d;

    logic sum_edge, in_entry, key_live;
    logic key_digit, key_next, key_clr;
    logic timeout;
    logic a_clr, a_set, a_push, b_clr, b_push;

    assign sum_edge  = suma_btn & ~btn_prev_q;
    assign in_entry  = (state_q == ST_ENTER_A) || (state_q == ST_ENTER_B) || (state_q == ST_SHOW);
    // A coincident sum edge takes priority, so the key is dropped
    assign key_live  = in_entry & ~sum_edge;
    assign key_digit = key_valid & is_digit(key_code);
    assign key_next  = key_valid & (key_code == KEY_NEXT);
    assign key_clr   = key_valid & (key_code == KEY_CLR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ENTER_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ENTER_A: begin
                if (in_entry && sum_edge)       state_d = ST_ADD;
                else if (key_live && key_clr)   state_d = ST_ENTER_A;
                else if (key_live && key_next)  state_d = ST_ENTER_B;
            end
            ST_ENTER_B: begin
                if (in_entry && sum_edge)       state_d = ST_ADD;
                else if (key_live && key_clr)   state_d = ST_ENTER_A;
            end
            ST_ADD:   state_d = ST_LATCH;
            ST_LATCH: state_d = ST_CONV;
            ST_CONV:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (conv_listo)                 state_d = ST_SHOW;
                else if (timeout)               state_d = ST_ENTER_A;
            end
            ST_SHOW: begin
                if (in_entry && sum_edge)                   state_d = ST_ADD;
                else if (key_live && (key_clr || key_digit)) state_d = ST_ENTER_A;
            end
            default:  state_d = ST_ENTER_A;
        endcase
    end

    always_comb begin
        add_en      = (state_q == ST_ADD);
        conv_start  = (state_q == ST_CONV);
        busy        = (state_q == ST_ADD) || (state_q == ST_LATCH) ||
                      (state_q == ST_CONV) || (state_q == ST_WAIT);
        disp_load_d = (state_q == ST_WAIT) && conv_listo;

        a_clr  = key_live && key_clr;
        a_set  = key_live && key_digit && (state_q == ST_SHOW);
        a_push = key_live && key_digit && (state_q == ST_ENTER_A);
        b_clr  = key_live && (key_clr ||
                              (key_next  && (state_q == ST_ENTER_A)) ||
                              (key_digit && (state_q == ST_SHOW)));
        b_push = key_live && key_digit && (state_q == ST_ENTER_B);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_prev_q   <= 1'b0;
            conv_value_q <= '0;
            disp_load_q  <= 1'b0;
        end else begin
            btn_prev_q  <= suma_btn;
            disp_load_q <= disp_load_d;
            if (state_q == ST_LATCH) begin
                conv_value_q <= resultado;
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int TO_W = (CONV_TIMEOUT < 2) ? 1 : $clog2(CONV_TIMEOUT + 1);

    logic [TO_W-1:0] wait_cnt_q;
    logic            err_q;

    // Fires on the CONV_TIMEOUT-th consecutive WAIT cycle without conv_listo
    assign timeout = (state_q == ST_WAIT) && !conv_listo &&
                     (wait_cnt_q == TO_W'(CONV_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= (state_q == ST_WAIT) ? wait_cnt_q + TO_W'(1) : '0;
            if (timeout) begin
                err_q <= 1'b1;
            end else if (key_live && key_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    sum_digit_acc #(
        .MAX_DIGITS (MAX_DIGITS)
    ) u_acc_a (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clr_i   (a_clr),
        .set_i   (a_set),
        .push_i  (a_push),
        .digit_i (key_code),
        .value_o (num1)
    );

    sum_digit_acc #(
        .MAX_DIGITS (MAX_DIGITS)
    ) u_acc_b (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clr_i   (b_clr),
        .set_i   (1'b0),
        .push_i  (b_push),
        .digit_i (key_code),
        .value_o (num2)
    );

    assign conv_value = conv_value_q;
    assign disp_load  = disp_load_q;

endmodule

// File: tb/tb_sum_sequencer.sv
// Directed bench for sum_sequencer; the watchdog section runs only when SEQ_TIMEOUT_EN is defined.
module tb_sum_sequencer;
    import sum_pkg::*;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        key_valid  = 1'b0;
    logic [3:0]  key_code   = 4'd0;
    logic        suma_btn   = 1'b0;
    logic [15:0] resultado  = 16'd0;
    logic        conv_listo = 1'b0;
    logic [11:0] num1, num2;
    logic        add_en, conv_start, disp_load, busy, err;
    logic [15:0] conv_value;

    int checks   = 0;
    int errors   = 0;
    int dl_count = 0;

    always #5 clk = ~clk;

    sum_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .suma_btn   (suma_btn),
        .resultado  (resultado),
        .conv_listo (conv_listo),
        .num1       (num1),
        .num2       (num2),
        .add_en     (add_en),
        .conv_value (conv_value),
        .conv_start (conv_start),
        .disp_load  (disp_load),
        .busy       (busy),
        .err        (err)
    );

    // Registered adder in front of the sequencer
    always @(posedge clk or negedge rst) begin
        if (!rst)        resultado <= 16'd0;
        else if (add_en) resultado <= 16'(num1) + 16'(num2);
    end

    always @(posedge clk) begin
        if (disp_load) dl_count++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input state_e exp);
        checks++;
        assert (dut.state_q === exp) else begin
            errors++;
            $error("FAIL %s: observed state %0d expected state %0d", tag, dut.state_q, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        tick();
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " num1"},       32'(num1),       32'd0);
        chk({tag, " num2"},       32'(num2),       32'd0);
        chk({tag, " conv_value"}, 32'(conv_value), 32'd0);
        chk({tag, " add_en"},     32'(add_en),     32'd0);
        chk({tag, " conv_start"}, 32'(conv_start), 32'd0);
        chk({tag, " disp_load"},  32'(disp_load),  32'd0);
        chk({tag, " busy"},       32'(busy),       32'd0);
        chk({tag, " err"},        32'(err),        32'd0);
        chk_state({tag, " state"}, ST_ENTER_A);
    endtask

    initial begin
        // Reset
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b1;
        tick();

        // 123 + 456
        key(4'd1); key(4'd2); key(4'd3);
        chk("num1 123", 32'(num1), 32'd123);
        key(4'hA);
        chk_state("next to B", ST_ENTER_B);
        chk("num2 cleared", 32'(num2), 32'd0);
        key(4'd4); key(4'd5); key(4'd6);
        chk("num2 456", 32'(num2), 32'd456);
        key(4'hA);
        chk_state("next ignored in B", ST_ENTER_B);
        chk("num2 kept", 32'(num2), 32'd456);

        suma_btn = 1'b1;
        tick();
        chk_state("add state", ST_ADD);
        chk("add_en pulse", 32'(add_en), 32'd1);
        chk("busy add", 32'(busy), 32'd1);
        tick();
        chk_state("latch state", ST_LATCH);
        chk("add_en drop", 32'(add_en), 32'd0);
        tick();
        chk_state("conv state", ST_CONV);
        chk("conv_value 579", 32'(conv_value), 32'd579);
        chk("conv_start pulse", 32'(conv_start), 32'd1);
        tick();
        chk_state("wait state", ST_WAIT);
        chk("conv_start drop", 32'(conv_start), 32'd0);
        key(4'd7);
        chk("key ignored in wait", 32'(num1), 32'd123);
        suma_btn = 1'b0;
        tick();
        suma_btn = 1'b1;
        tick();
        suma_btn = 1'b0;
        chk_state("edge ignored in wait", ST_WAIT);
        chk("no early disp_load", 32'(disp_load), 32'd0);
        conv_listo = 1'b1;
        tick();
        conv_listo = 1'b0;
        chk_state("show state", ST_SHOW);
        chk("disp_load pulse", 32'(disp_load), 32'd1);
        chk("busy show", 32'(busy), 32'd0);
        tick();
        chk("disp_load drop", 32'(disp_load), 32'd0);
        chk("one disp_load", 32'(dl_count), 32'd1);

        // Digit in SHOW restarts entry
        key(4'd7);
        chk("show digit num1", 32'(num1), 32'd7);
        chk("show digit num2", 32'(num2), 32'd0);
        chk_state("show digit state", ST_ENTER_A);
        key(4'd9); key(4'd9); key(4'd9);
        chk("count limit 799", 32'(num1), 32'd799);

        // Clear, then 9999
        key(4'hB);
        chk("clear num1", 32'(num1), 32'd0);
        chk_state("clear state", ST_ENTER_A);
        key(4'd9); key(4'd9); key(4'd9); key(4'd9);
        chk("num1 999", 32'(num1), 32'd999);

        // Key coincident with sum edge is dropped
        key_valid = 1'b1;
        key_code  = 4'd5;
        suma_btn  = 1'b1;
        tick();
        key_valid = 1'b0;
        key_code  = 4'd0;
        chk_state("edge wins", ST_ADD);
        chk("edge wins num1", 32'(num1), 32'd999);
        tick();
        tick();
        chk("conv_value 999", 32'(conv_value), 32'd999);
        tick();
        chk_state("wait before reset", ST_WAIT);

        // Asynchronous reset in WAIT
        rst      = 1'b0;
        suma_btn = 1'b0;
        #1;
        chk_all_zero("reset in wait");
        conv_listo = 1'b1;
        tick();
        conv_listo = 1'b0;
        rst        = 1'b1;
        tick();
        tick();
        tick();
        chk("no disp_load after reset", 32'(dl_count), 32'd1);
        chk_state("idle after reset", ST_ENTER_A);

`ifdef SEQ_TIMEOUT_EN
        key(4'd1); key(4'hA); key(4'd2);
        suma_btn = 1'b1;
        tick();
        suma_btn = 1'b0;
        tick();
        tick();
        tick();
        chk("conv_value 3", 32'(conv_value), 32'd3);
        repeat (254) tick();
        chk_state("still waiting", ST_WAIT);
        chk("err not yet", 32'(err), 32'd0);
        tick();
        chk_state("timeout state", ST_ENTER_A);
        chk("err set", 32'(err), 32'd1);
        chk("no disp_load on timeout", 32'(dl_count), 32'd1);
        key(4'hB);
        chk("err cleared", 32'(err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_sequencer.md
SUM_SEQUENCER -- requirements
Module: sum_sequencer

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 3: maximum decimal digits accepted per operand.
REQ-002 SHALL have parameter CONV_TIMEOUT, default 255: cycles to wait for conv_listo; used only with SEQ_TIMEOUT_EN.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port key_valid  in  1  one-cycle strobe qualifying key_code.
REQ-006 SHALL have port key_code  in  4  key value: 0x0-0x9 digit, 0xA next operand, 0xB clear, others ignored.
REQ-007 SHALL have port suma_btn  in  1  level from the sum button, already debounced.
REQ-008 SHALL have port resultado  in  16  registered sum from the adder.
REQ-009 SHALL have port conv_listo  in  1  done flag from the binary-to-BCD converter.
REQ-010 SHALL have port num1  out  12  first operand, binary, 0-999.
REQ-011 SHALL have port num2  out  12  second operand, binary, 0-999.
REQ-012 SHALL have port add_en  out  1  one-cycle adder enable pulse.
REQ-013 SHALL have port conv_value  out  16  latched sum presented to the converter.
REQ-014 SHALL have port conv_start  out  1  one-cycle converter start pulse.
REQ-015 SHALL have port disp_load  out  1  one-cycle pulse that latches the display digits.
REQ-016 SHALL have port busy  out  1  high in ADD, LATCH, CONV and WAIT.
REQ-017 SHALL have port err  out  1  sticky conversion-timeout flag.

Function
REQ-018 States SHALL be ENTER_A, ENTER_B, ADD, LATCH, CONV, WAIT and SHOW.
REQ-019 In ENTER_A or ENTER_B, a digit d SHALL update the active operand to operand*10+d and increment its digit count.
REQ-020 A digit arriving when the digit count equals MAX_DIGITS SHALL be ignored.
REQ-021 Key 0xA in ENTER_A SHALL transition to ENTER_B with num2=0 and count=0; in ENTER_B it SHALL be ignored.
REQ-022 Key 0xB in ENTER_A, ENTER_B or SHOW SHALL zero num1, num2 and both counts and go to ENTER_A.
REQ-023 A rising edge of suma_btn, detected with a registered previous value, in ENTER_A, ENTER_B or SHOW SHALL transition to ADD.
REQ-024 If key_valid and a suma_btn edge coincide, the edge SHALL win and the key SHALL be dropped.
REQ-025 ADD SHALL assert add_en for one cycle then go to LATCH.
REQ-026 LATCH SHALL capture resultado into conv_value then go to CONV.
REQ-027 CONV SHALL assert conv_start for one cycle then go to WAIT.
REQ-028 WAIT SHALL hold until conv_listo is sampled high, then pulse disp_load and go to SHOW.
REQ-029 Latency from the suma_btn edge to disp_load SHALL be 4 cycles plus the converter latency.
REQ-030 In SHOW a digit key SHALL zero both operands, load the digit into num1 with count 1, and go to ENTER_A.
REQ-031 All key_valid events in ADD, LATCH, CONV and WAIT SHALL be ignored, and suma_btn edges there SHALL be ignored.
REQ-032 Operand arithmetic SHALL be unsigned 12-bit and SHALL never exceed 999.

Reset
REQ-033 On rst low, the state SHALL become ENTER_A and num1, num2, conv_value, counts, add_en, conv_start, disp_load, busy and err SHALL all become 0.
REQ-034 Reset mid-sequence SHALL abort immediately, with no trailing pulse after release.

Configuration
REQ-035 With SEQ_TIMEOUT_EN defined, a WAIT cycle counter SHALL, after CONV_TIMEOUT cycles without conv_listo, set err, skip disp_load and go to ENTER_A.
REQ-036 err SHALL clear on key 0xB.
REQ-037 Without SEQ_TIMEOUT_EN, WAIT SHALL wait indefinitely and err SHALL be tied to 0.

Structure
REQ-038 Package sum_pkg SHALL hold the state enum, the key-code constants (KEY_NEXT=0xA, KEY_CLR=0xB) and the operand and result widths.
REQ-039 Sub-module sum_digit_acc (one operand accumulator with digit counter) SHALL be instantiated twice.

Verification
REQ-040 Keys 1,2,3,A,4,5,6 then a suma_btn edge -> num1=123, num2=456, conv_value=579, one disp_load after conv_listo.
REQ-041 Keys 9,9,9,9 -> num1=999; the fourth digit is ignored.
REQ-042 key_valid with code 5 on the same cycle as the suma_btn edge -> state ADD, num1 unchanged.
REQ-043 rst asserted in WAIT -> all outputs 0 and state ENTER_A, with no disp_load after release.
REQ-044 With SEQ_TIMEOUT_EN, conv_listo held low -> err=1 after 255 WAIT cycles and state ENTER_A; key 0xB then clears err.
REQ-045 In SHOW, key 7 -> num1=7, num2=0, state ENTER_A.
